// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and the burst-master state type.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B
  } mst_state_e;

endpackage

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 initiator: INCR read bursts streamed back beat by beat,
// single-beat strobed writes, one response port shared by both.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int         DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [7:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_last,
  output logic                rsp_err,

  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [31:0]         io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,

  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,

  output logic                io_master_bready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  input  logic [3:0]          io_master_bid,

  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [31:0]         io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,

  output logic                io_master_rready,
  input  logic                io_master_rvalid,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [3:0]          io_master_rid
);

  mst_state_e          state;
  logic                req_ready_q;
  logic                arvalid_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic [7:0]          beat_cnt;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic final_beat;
  logic r_hs;
  logic b_hs;
  logic aw_done;
  logic w_done;

  assign final_beat = (beat_cnt == 8'd0);
  assign r_hs       = (state == ST_R) && io_master_rvalid && io_master_rready;
  assign b_hs       = (state == ST_B) && io_master_bvalid && io_master_bready;
  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign aw_done    = !awvalid_q || io_master_awready;
  assign w_done     = !wvalid_q  || io_master_wready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      req_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      beat_cnt    <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (req_write) begin
              state     <= ST_AW_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              beat_cnt  <= 8'd0;
            end else begin
              state     <= ST_AR;
              arvalid_q <= 1'b1;
              beat_cnt  <= req_len;
            end
          end
        end
        ST_AR: begin
          if (io_master_arready) begin
            arvalid_q <= 1'b0;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (r_hs) begin
            if (final_beat) begin
              state       <= ST_IDLE;
              req_ready_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        ST_AW_W: begin
          if (io_master_awready) awvalid_q <= 1'b0;
          if (io_master_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) state <= ST_B;
        end
        ST_B: begin
          if (b_hs) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are only observed after being loaded on accept.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && req_valid) begin
      addr_q  <= req_addr;
      len_q   <= req_len;
      size_q  <= req_size;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    io_master_rready = 1'b0;
    io_master_bready = 1'b0;
    rsp_valid        = 1'b0;
    rsp_data         = '0;
    rsp_last         = 1'b0;
    rsp_err          = 1'b0;
    case (state)
      ST_R: begin
        io_master_rready = rsp_ready;
        rsp_valid        = io_master_rvalid;
        rsp_data         = io_master_rdata;
        rsp_last         = final_beat;
        rsp_err          = io_master_rvalid &&
                           ((io_master_rlast != final_beat) ||
                            (io_master_rid != AXI_ID) || io_master_rresp[1]);
      end
      ST_B: begin
        io_master_bready = rsp_ready;
        rsp_valid        = io_master_bvalid;
        rsp_last         = 1'b1;
        rsp_err          = io_master_bvalid &&
                           (io_master_bresp[1] || (io_master_bid != AXI_ID));
      end
      default: ;
    endcase
  end

  assign req_ready         = req_ready_q;

  assign io_master_awvalid = awvalid_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = BURST_INCR;

  assign io_master_wvalid  = wvalid_q;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;

  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = BURST_INCR;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: behavioural AXI slave, response monitor, table vectors,
// hand-written corner sequences and randomized transactions against a reference model.
module tb_axi4_burst_master;

  localparam int         DATA_W = 32;
  localparam logic [3:0] AXI_ID = 4'h0;

  logic clock, reset;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic awvalid, awready, wvalid, wready, wlast, bready, bvalid, arvalid, arready;
  logic rready, rvalid, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          err_beat;
    logic [1:0]  err_resp;
    logic [1:0]  bresp;
    logic        bad_id;
    logic        bad_last;
    int          rsp_mode;
    logic        w_after_aw;
    logic        rand_ready;
    logic        rgap;
    int          exp_beats;
    logic        exp_err_any;
  } vec_t;

  typedef struct { logic [31:0] data; logic last; logic err; } rsp_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic [3:0] id; } a_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

  rsp_t rsp_q[$];
  a_t   ar_log[$];
  a_t   aw_log[$];
  w_t   w_log[$];

  int          cfg_err_beat = -1;
  logic [1:0]  cfg_err_resp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;
  logic        cfg_bad_id = 1'b0, cfg_bad_last = 1'b0, cfg_w_after_aw = 1'b0;
  logic        cfg_rand_ready = 1'b0, cfg_rgap = 1'b0, cfg_ovr_en = 1'b0;
  logic [31:0] cfg_ovr = 32'h0;
  int          cfg_rsp_mode = 0;

  axi4_burst_master #(.AXI_ID(AXI_ID), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic sample;
    @(negedge clock); #1;
  endtask

  // Memory contents seen by the slave; the reference model reads the same image.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (cfg_ovr_en) return cfg_ovr;
    return (a * 32'h9e37_79b1) ^ 32'h1234_5678;
  endfunction

  // Responses are recorded when valid & ready are seen half a cycle before the handshake edge.
  always @(negedge clock)
    if (reset && rsp_valid && rsp_ready)
      rsp_q.push_back('{data: rsp_data, last: rsp_last, err: rsp_err});

  // Behavioural AXI slave plus rsp_ready driver.
  initial begin
    bit   ar_hs, r_hs, aw_hs, w_hs, b_hs;
    a_t   cap_a, cap_aw;
    w_t   cap_w;
    bit   rd_active = 0, aw_seen = 0, w_seen = 0;
    int   rd_idx = 0, rd_len = 0;
    logic [31:0] rd_addr = 0;
    logic [2:0]  rd_size = 0;
    {arready, awready, wready, rvalid, bvalid, rlast} = '0;
    rdata = '0; rresp = '0; rid = '0; bresp = '0; bid = '0; rsp_ready = 1'b0;
    forever begin
      @(negedge clock);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      cap_a  = '{addr: araddr, len: arlen, size: arsize, burst: arburst, id: arid};
      cap_aw = '{addr: awaddr, len: awlen, size: awsize, burst: awburst, id: awid};
      cap_w  = '{data: wdata, strb: wstrb, last: wlast};
      @(posedge clock); #1;
      case (cfg_rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ~rsp_ready;
        default: rsp_ready = 1'($urandom % 2);
      endcase
      if (!reset) begin
        {arready, awready, wready, rvalid, bvalid, rlast} = '0;
        rd_active = 0; aw_seen = 0; w_seen = 0;
        continue;
      end
      if (ar_hs) begin
        ar_log.push_back(cap_a);
        rd_active = 1; rd_idx = 0; rd_len = int'(cap_a.len);
        rd_addr = cap_a.addr; rd_size = cap_a.size;
      end
      if (r_hs) begin
        rvalid = 1'b0;
        rd_idx++;
        if (rd_idx > rd_len) rd_active = 0;
      end
      if (rd_active && !rvalid && (!cfg_rgap || ($urandom % 2) == 0)) begin
        rvalid = 1'b1;
        rdata  = mem_word(rd_addr + (32'(rd_idx) << rd_size));
        rresp  = (rd_idx == cfg_err_beat) ? cfg_err_resp : 2'b00;
        rlast  = (rd_idx == rd_len) ^ cfg_bad_last;
        rid    = cfg_bad_id ? 4'h5 : AXI_ID;
      end
      if (aw_hs) begin aw_log.push_back(cap_aw); aw_seen = 1; end
      if (w_hs)  begin w_log.push_back(cap_w);   w_seen = 1; end
      if (b_hs) bvalid = 1'b0;
      if (aw_seen && w_seen && !bvalid) begin
        bvalid = 1'b1;
        bresp  = cfg_bresp;
        bid    = cfg_bad_id ? 4'h9 : AXI_ID;
        aw_seen = 0; w_seen = 0;
      end
      arready = cfg_rand_ready ? 1'($urandom % 2) : 1'b1;
      awready = cfg_rand_ready ? 1'($urandom % 2) : 1'b1;
      wready  = cfg_w_after_aw ? (aw_seen && !w_seen) :
                (cfg_rand_ready ? 1'($urandom % 2) : 1'b1);
    end
  end

  function automatic vec_t mk_rd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                 input int err_beat, input logic [1:0] err_resp, input logic bad_id,
                                 input logic bad_last, input int rsp_mode, input logic rand_ready,
                                 input logic rgap, input int exp_beats, input logic exp_err);
    vec_t v;
    v = '{write: 1'b0, addr: addr, len: len, size: size, wdata: 32'h0, wstrb: 4'h0,
          err_beat: err_beat, err_resp: err_resp, bresp: 2'b00, bad_id: bad_id, bad_last: bad_last,
          rsp_mode: rsp_mode, w_after_aw: 1'b0, rand_ready: rand_ready, rgap: rgap,
          exp_beats: exp_beats, exp_err_any: exp_err};
    return v;
  endfunction

  function automatic vec_t mk_wr(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] wd,
                                 input logic [3:0] ws, input logic [1:0] br, input logic bad_id,
                                 input logic w_after_aw, input int rsp_mode, input logic rand_ready,
                                 input logic exp_err);
    vec_t v;
    v = '{write: 1'b1, addr: addr, len: len, size: 3'd2, wdata: wd, wstrb: ws,
          err_beat: -1, err_resp: 2'b00, bresp: br, bad_id: bad_id, bad_last: 1'b0,
          rsp_mode: rsp_mode, w_after_aw: w_after_aw, rand_ready: rand_ready, rgap: 1'b0,
          exp_beats: 1, exp_err_any: exp_err};
    return v;
  endfunction

  task automatic apply_cfg(input vec_t v);
    cfg_err_beat = v.err_beat; cfg_err_resp = v.err_resp; cfg_bresp = v.bresp;
    cfg_bad_id = v.bad_id; cfg_bad_last = v.bad_last; cfg_w_after_aw = v.w_after_aw;
    cfg_rand_ready = v.rand_ready; cfg_rgap = v.rgap; cfg_rsp_mode = v.rsp_mode;
  endtask

  task automatic clear_logs;
    rsp_q.delete(); ar_log.delete(); aw_log.delete(); w_log.delete();
  endtask

  task automatic drive_req(input vec_t v);
    req_write = v.write; req_addr = v.addr; req_len = v.len; req_size = v.size;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
  endtask

  task automatic issue(input vec_t v, input string tag, output bit ok);
    drive_req(v);
    req_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      sample;
      if (req_ready) begin ok = 1; break; end
    end
    check({tag, ".accept"}, 64'(ok), 64'd1);
    if (!ok) begin req_valid = 1'b0; return; end
    check({tag, ".no_valid_before_accept"}, 64'({arvalid, awvalid, wvalid}), 64'd0);
    tick;
    req_valid = 1'b0;
    sample;
    if (v.write) check({tag, ".aw_w_valid_next_cycle"}, 64'({awvalid, wvalid}), 64'b11);
    else         check({tag, ".arvalid_next_cycle"}, 64'(arvalid), 64'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rsp_q.size() >= n && req_ready) begin ok = 1; break; end
      sample;
    end
    check({tag, ".completes"}, 64'(ok), 64'd1);
  endtask

  // Reference model: expected beats follow the INCR address rule and the error rules directly.
  task automatic check_txn(input vec_t v, input string tag);
    int n;
    n = v.write ? 1 : int'(v.len) + 1;
    check({tag, ".beats"}, 64'(rsp_q.size()), 64'(n));
    for (int i = 0; i < n && i < rsp_q.size(); i++) begin
      logic [31:0] ed;
      logic ee;
      if (v.write) begin
        ed = 32'h0;
        ee = v.bresp[1] || v.bad_id;
      end else begin
        ed = mem_word(v.addr + 32'(i) * (32'd1 << v.size));
        ee = ((i == v.err_beat) && v.err_resp[1]) || v.bad_id || v.bad_last;
      end
      check($sformatf("%s.b%0d.data", tag, i), 64'(rsp_q[i].data), 64'(ed));
      check($sformatf("%s.b%0d.last", tag, i), 64'(rsp_q[i].last), 64'(i == n - 1));
      check($sformatf("%s.b%0d.err", tag, i), 64'(rsp_q[i].err), 64'(ee));
    end
    if (!v.write) begin
      check({tag, ".ar_count"}, 64'(ar_log.size()), 64'd1);
      check({tag, ".aw_count"}, 64'(aw_log.size()), 64'd0);
      if (ar_log.size() > 0)
        check({tag, ".ar_fields"},
              64'({ar_log[0].addr, ar_log[0].len, ar_log[0].size, ar_log[0].burst, ar_log[0].id}),
              64'({v.addr, v.len, v.size, 2'b01, AXI_ID}));
    end else begin
      check({tag, ".aw_w_ar_count"}, 64'({8'(aw_log.size()), 8'(w_log.size()), 8'(ar_log.size())}),
            64'({8'd1, 8'd1, 8'd0}));
      if (aw_log.size() > 0)
        check({tag, ".aw_fields"},
              64'({aw_log[0].addr, aw_log[0].len, aw_log[0].size, aw_log[0].burst, aw_log[0].id}),
              64'({v.addr, 8'd0, v.size, 2'b01, AXI_ID}));
      if (w_log.size() > 0)
        check({tag, ".w_fields"}, 64'({w_log[0].data, w_log[0].strb, w_log[0].last}),
              64'({v.wdata, v.wstrb, 1'b1}));
    end
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    bit ok;
    apply_cfg(v);
    clear_logs();
    tick;
    issue(v, tag, ok);
    if (!ok) return;
    if (v.write && v.w_after_aw && !v.rand_ready) begin
      sample;
      check({tag, ".aw_drops_w_held_wlast"}, 64'({awvalid, wvalid, wlast}), 64'b011);
    end
    wait_done(v.write ? 1 : int'(v.len) + 1, tag);
    check_txn(v, tag);
  endtask

  vec_t table_v[$];

  initial begin
    vec_t v, v2;
    bit   ok, done;
    int   viol;
    logic any_err;

    reset = 1'b0; req_valid = 1'b0;
    req_write = 1'b0; req_addr = '0; req_len = '0; req_size = 3'd2; req_wdata = '0; req_wstrb = '0;
    repeat (3) tick;
    sample;
    check("reset.outputs", 64'({req_ready, arvalid, awvalid, wvalid, rready, bready, rsp_valid}),
          64'b1000000);
    tick;
    reset = 1'b1;
    tick;

    // Single-beat read with a fixed data word.
    cfg_ovr_en = 1'b1; cfg_ovr = 32'hdeadbeef;
    run_and_check(mk_rd(32'h8000_0000, 8'd0, 3'd2, -1, 2'b00, 0, 0, 0, 0, 0, 1, 0), "rd_single");
    if (rsp_q.size() > 0) check("rd_single.deadbeef", 64'(rsp_q[0].data), 64'hdeadbeef);
    cfg_ovr_en = 1'b0;

    table_v.push_back(mk_rd(32'h8000_0100, 8'd3, 3'd2, -1, 2'b00, 0, 0, 1, 0, 0, 4, 0));
    table_v.push_back(mk_wr(32'ha000_03f8, 8'd5, 32'h41, 4'b0001, 2'b00, 0, 1, 0, 0, 0));
    table_v.push_back(mk_wr(32'h0000_1000, 8'd0, 32'h1234_abcd, 4'b1111, 2'b10, 0, 0, 0, 0, 1));
    table_v.push_back(mk_rd(32'h0000_2000, 8'd1, 3'd2, 1, 2'b11, 0, 0, 0, 0, 0, 2, 1));
    table_v.push_back(mk_rd(32'h0000_3000, 8'd2, 3'd2, -1, 2'b00, 0, 1, 0, 0, 0, 3, 1));
    table_v.push_back(mk_wr(32'h0000_4004, 8'd0, 32'hcafe_f00d, 4'b1100, 2'b00, 1, 0, 1, 0, 1));
    table_v.push_back(mk_rd(32'h0000_5000, 8'd0, 3'd2, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0));
    table_v.push_back(mk_rd(32'h0000_6000, 8'd15, 3'd2, -1, 2'b00, 0, 0, 2, 1, 1, 16, 0));
    table_v.push_back(mk_wr(32'h0000_7008, 8'd0, 32'h0bad_beef, 4'b0110, 2'b01, 0, 1, 2, 0, 0));
    table_v.push_back(mk_rd(32'h0000_8001, 8'd2, 3'd0, -1, 2'b00, 1, 0, 0, 1, 0, 3, 1));

    for (int t = 0; t < table_v.size(); t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      run_and_check(table_v[t], tag);
      any_err = 1'b0;
      foreach (rsp_q[i]) any_err |= rsp_q[i].err;
      check({tag, ".exp_beats"}, 64'(rsp_q.size()), 64'(table_v[t].exp_beats));
      check({tag, ".exp_err_any"}, 64'(any_err), 64'(table_v[t].exp_err_any));
    end

    // req_valid held high across a read: no second accept until the last beat handshakes.
    v = mk_rd(32'h0000_7000, 8'd2, 3'd2, -1, 2'b00, 0, 0, 0, 0, 0, 3, 0);
    v2 = v; v2.addr = 32'h0000_7100;
    apply_cfg(v); clear_logs(); tick;
    drive_req(v); req_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin sample; if (req_ready) begin ok = 1; break; end end
    check("hold.accept1", 64'(ok), 64'd1);
    tick;
    viol = 0; done = 0;
    for (int c = 0; c < 500; c++) begin
      sample;
      if (req_ready) viol++;
      if (rsp_q.size() >= 3) begin done = 1; break; end
    end
    check("hold.first_done", 64'(done), 64'd1);
    check("hold.req_ready_low_while_busy", 64'(viol), 64'd0);
    check_txn(v, "hold1");
    rsp_q.delete(); ar_log.delete();
    req_addr = v2.addr;
    sample;
    check("hold.req_ready_after_last", 64'(req_ready), 64'd1);
    check("hold.no_early_second_ar", 64'({arvalid, 8'(ar_log.size())}), 64'd0);
    tick;
    req_valid = 1'b0;
    sample;
    check("hold.second_arvalid", 64'(arvalid), 64'd1);
    wait_done(3, "hold2");
    check_txn(v2, "hold2");

    // Reset during beat 2 of a 4-beat burst.
    v = mk_rd(32'h0000_9000, 8'd3, 3'd2, -1, 2'b00, 0, 0, 0, 0, 0, 4, 0);
    apply_cfg(v); clear_logs(); tick;
    issue(v, "rst_burst", ok);
    done = 0;
    for (int c = 0; c < 200; c++) begin
      if (rsp_q.size() >= 1) begin done = 1; break; end
      sample;
    end
    check("rst.first_beat_seen", 64'(done), 64'd1);
    tick;
    #2 reset = 1'b0;
    #1 check("rst.outputs_cleared",
             64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid, req_ready}), 64'b0000001);
    repeat (3) tick;
    reset = 1'b1;
    sample;
    check("rst.no_response_issued", 64'(rsp_q.size()), 64'd1);
    check("rst.req_ready_after_release", 64'(req_ready), 64'd1);
    run_and_check(mk_rd(32'h0000_a000, 8'd2, 3'd2, -1, 2'b00, 0, 0, 1, 0, 0, 3, 0), "rst_fresh");

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] l;
      logic [2:0] s;
      l = 8'($urandom_range(7, 0));
      s = 3'($urandom_range(2, 0));
      if ($urandom % 2) begin
        v = mk_wr($urandom & 32'hffff_fffc, l, $urandom, 4'($urandom), 2'($urandom),
                  1'(($urandom % 8) == 0), 1'($urandom % 2), int'($urandom_range(2, 0)),
                  1'($urandom % 2), 1'b0);
      end else begin
        v = mk_rd($urandom & 32'hffff_fff0, l, s,
                  (($urandom % 3) == 0) ? int'($urandom_range(int'(l), 0)) : -1,
                  2'($urandom), 1'(($urandom % 8) == 0), 1'(($urandom % 10) == 0),
                  int'($urandom_range(2, 0)), 1'b1, 1'($urandom % 2), 0, 1'b0);
      end
      run_and_check(v, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
